// File: rtl/alu_sequencer_if.sv
// Control-unit side of the ALU sequencer: operand bus, op request and result return.
// The control unit is the master; the sequencer is the slave.
interface alu_sequencer_if;
  logic [15:0] bus_in;
  logic        load_a;
  logic        load_b;
  logic        start;
  logic [2:0]  op;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  flags;

  modport master (
    output bus_in,
    output load_a,
    output load_b,
    output start,
    output op,
    input  busy,
    input  done,
    input  result,
    input  flags
  );

  modport slave (
    input  bus_in,
    input  load_a,
    input  load_b,
    input  start,
    input  op,
    output busy,
    output done,
    output result,
    output flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// Initiator-side controller for the 16-bit ALU: latches operands, issues an op over the
// ALU's two-cycle registered timing, and holds the captured result and flags.
module alu_sequencer #(
  parameter logic [15:0] DIV0_RESULT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_sequencer_if.slave        ctl_io,
  output logic [15:0]           alu_a_o,
  output logic [15:0]           alu_b_o,
  output logic [2:0]            alu_sel_o,
  output logic                  alu_oe_o,
  input  logic [15:0]           alu_o_i,
  input  logic [7:0]            alu_f_i
);

  localparam logic [2:0] OpDiv = 3'b101;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  flags_q, flags_d;
  logic        in_flight;
  logic        unused_flags;

  assign unused_flags = ^alu_f_i[7:2];
  assign in_flight    = (state_q == StIssue) || (state_q == StCapture);

  // Operands are frozen while the ALU is enabled so they stay stable through CAPTURE.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (!in_flight) begin
      if (ctl_io.load_a) a_d = ctl_io.bus_in;
      if (ctl_io.load_b) b_d = ctl_io.bus_in;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      StIdle: begin
        if (ctl_io.start) begin
          sel_d = ctl_io.op;
          // b_d includes a same-edge load, so the divisor check sees the new operand.
          if ((ctl_io.op == OpDiv) && (b_d == 16'h0000)) begin
            state_d  = StDone;
            result_d = DIV0_RESULT;
            flags_d  = 8'h08;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        result_d = alu_o_i;
        flags_d  = {5'b0_0000, alu_o_i[15], alu_f_i[1], alu_f_i[0]};
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign ctl_io.busy   = in_flight;
  assign ctl_io.done   = (state_q == StDone);
  assign ctl_io.result = result_q;
  assign ctl_io.flags  = flags_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_sel_o     = sel_q;
  assign alu_oe_o      = in_flight;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural registered ALU and a result scoreboard.
module tb_alu_sequencer;
  logic        clk;
  logic        rst;
  logic [15:0] alu_a, alu_b, alu_o;
  logic [2:0]  alu_sel;
  logic        alu_oe;
  logic [7:0]  alu_f;
  logic [16:0] alu_reg;

  int tests = 0;
  int fails = 0;
  int oe_cnt = 0;
  logic [15:0] last_res = '0;
  logic [23:0] sb[$];

  alu_sequencer_if ifc ();

  alu_sequencer #(.DIV0_RESULT(16'hFFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctl_io    (ifc),
    .alu_a_o   (alu_a),
    .alu_b_o   (alu_b),
    .alu_sel_o (alu_sel),
    .alu_oe_o  (alu_oe),
    .alu_o_i   (alu_o),
    .alu_f_i   (alu_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] sel);
    logic [31:0] p;
    p = a * b;
    case (sel)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {1'b0, a} + 17'd1;
      3'b011:  return {1'b0, a} - 17'd1;
      3'b100:  return p[16:0];
      3'b101:  return (b == 16'h0) ? 17'h0FFFF : {1'b0, a / b};
      3'b110:  return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // ALU model: registers while enabled, clears when disabled; junk in flag bits 7:2.
  always @(posedge clk or posedge rst) begin
    if (rst) alu_reg <= '0;
    else if (alu_oe) alu_reg <= alu_calc(alu_a, alu_b, alu_sel);
    else alu_reg <= '0;
  end
  assign alu_o = alu_reg[15:0];
  assign alu_f = {6'b101101, alu_reg[16], (alu_reg[15:0] == 16'h0)};

  always @(negedge clk) if (alu_oe) oe_cnt <= oe_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/busy"}, ifc.busy, 0);
    chk({tag, "/done"}, ifc.done, 0);
    chk({tag, "/alu_a"}, alu_a, 0);
    chk({tag, "/alu_b"}, alu_b, 0);
    chk({tag, "/alu_sel"}, alu_sel, 0);
    chk({tag, "/alu_oe"}, alu_oe, 0);
    chk({tag, "/result"}, ifc.result, 0);
    chk({tag, "/flags"}, ifc.flags, 0);
  endtask

  task automatic load(input logic [15:0] v, input bit la, input bit lb);
    ifc.bus_in = v;
    ifc.load_a = la;
    ifc.load_b = lb;
    tick();
    ifc.load_a = 1'b0;
    ifc.load_b = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [15:0] ea,
                       input logic [15:0] eb, input logic [15:0] er, input logic [7:0] ef,
                       input int lat, input bit hazard);
    int cyc;
    int oe0;
    logic [23:0] exp;
    sb.push_back({er, ef});
    oe0 = oe_cnt;
    ifc.op = o;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    ifc.load_a = 1'b0;
    ifc.load_b = 1'b0;
    cyc = 1;
    while (!ifc.done && cyc <= 8) begin
      chk({tag, "/busy"}, ifc.busy, 1);
      chk({tag, "/alu_oe"}, alu_oe, 1);
      chk({tag, "/alu_a"}, alu_a, ea);
      chk({tag, "/alu_b"}, alu_b, eb);
      chk({tag, "/alu_sel"}, alu_sel, o);
      chk({tag, "/held_result"}, ifc.result, last_res);
      if (hazard) begin
        ifc.start = 1'b1;
        ifc.load_a = 1'b1;
        ifc.bus_in = 16'h1234;
      end
      tick();
      cyc++;
    end
    ifc.start = 1'b0;
    ifc.load_a = 1'b0;
    chk({tag, "/done_latency"}, cyc, lat);
    exp = sb.pop_front();
    chk({tag, "/result"}, ifc.result, exp[23:8]);
    chk({tag, "/flags"}, ifc.flags, exp[7:0]);
    chk({tag, "/busy_at_done"}, ifc.busy, 0);
    chk({tag, "/oe_at_done"}, alu_oe, 0);
    chk({tag, "/oe_cycles"}, oe_cnt - oe0, (lat == 1) ? 0 : 2);
    last_res = er;
    tick();
    chk({tag, "/done_pulse"}, ifc.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.bus_in = '0;
    ifc.load_a = 1'b0;
    ifc.load_b = 1'b0;
    ifc.start = 1'b0;
    ifc.op = '0;
    #3;
    chk_all_zero("reset");
    tick();
    rst = 1'b0;

    load(16'hFFFF, 1, 0);
    load(16'h0001, 0, 1);
    do_op("add_carry", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 8'h03, 3, 0);

    load(16'h0005, 1, 1);
    load(16'h0003, 1, 0);
    do_op("sub_borrow", 3'b001, 16'h0003, 16'h0005, 16'hFFFE, 8'h06, 3, 0);

    load(16'h0007, 1, 0);
    load(16'h0000, 0, 1);
    do_op("div0", 3'b101, 16'h0007, 16'h0000, 16'hFFFF, 8'h08, 1, 0);

    load(16'h0002, 0, 1);
    do_op("div", 3'b101, 16'h0007, 16'h0002, 16'h0003, 8'h00, 3, 0);

    load(16'h0003, 1, 0);
    ifc.bus_in = 16'h0004;
    ifc.load_b = 1'b1;
    do_op("same_edge_mul", 3'b100, 16'h0003, 16'h0004, 16'h000C, 8'h00, 3, 0);

    load(16'h0100, 1, 1);
    do_op("mul_carry", 3'b100, 16'h0100, 16'h0100, 16'h0000, 8'h03, 3, 0);

    load(16'hFFFF, 1, 0);
    do_op("inc_wrap", 3'b010, 16'hFFFF, 16'h0100, 16'h0000, 8'h03, 3, 0);

    load(16'h0007, 1, 0);
    load(16'h0002, 0, 1);
    do_op("hazard", 3'b110, 16'h0007, 16'h0002, 16'h0002, 8'h00, 3, 1);
    chk("hazard/a_kept", alu_a, 16'h0007);
    for (int i = 0; i < 3; i++) begin
      chk("hazard/no_extra_done", ifc.done, 0);
      chk("hazard/no_extra_busy", ifc.busy, 0);
      tick();
    end

    // Abort in CAPTURE: async reset clears everything without waiting for an edge.
    ifc.op = 3'b111;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    tick();
    chk("rst_mid/in_capture", alu_oe, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    last_res = '0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid/no_done", ifc.done, 0);
      chk("rst_mid/idle", ifc.busy, 0);
      tick();
    end

    load(16'h0002, 1, 0);
    load(16'h0003, 0, 1);
    do_op("after_rst_or", 3'b111, 16'h0002, 16'h0003, 16'h0003, 8'h00, 3, 0);

    ifc.bus_in = 16'h0000;
    ifc.load_b = 1'b1;
    do_op("div0_same_edge", 3'b101, 16'h0002, 16'h0000, 16'hFFFF, 8'h08, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
